// File: rtl/regs.sv
// regs: RV32I integer register file (32 x XLEN, x0 hardwired to zero) with
// two combinational read ports, one synchronous write-back port, and a
// per-register pending-write scoreboard used by ID for RAW hazard detection.
// Optional feature macro: REGS_WB_BYPASS_EN (write-first forwarding of the
// write-back value and retiring writer onto the read ports).
module regs #(
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      id_reg1_raddr_i,
  input  logic [4:0]      id_reg2_raddr_i,
  output logic [XLEN-1:0] regs_reg1_rdata_o,
  output logic [XLEN-1:0] regs_reg2_rdata_o,
  output logic            regs_reg1_busy_o,
  output logic            regs_reg2_busy_o,
  input  logic            id_alloc_i,
  input  logic [4:0]      id_reg_waddr_i,
  output logic            regs_alloc_ready_o,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_waddr_i,
  input  logic [XLEN-1:0] wb_wdata_i,
  output logic            regs_sb_err_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [XLEN-1:0]   rf  [32];
  logic [PEND_W-1:0] cnt [32];
  logic              sb_err;

  logic        wb_hit;
  logic        alloc_hit;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;
  logic        underflow;

  // Qualified write-back and allocation strobes, decoded to one-hot per register
  always_comb begin
    wb_hit    = wb_we_i && (wb_waddr_i != '0);
    alloc_hit = id_alloc_i && regs_alloc_ready_o && (id_reg_waddr_i != '0);
    inc_vec   = '0;
    dec_vec   = '0;
    if (alloc_hit) inc_vec[id_reg_waddr_i] = 1'b1;
    if (wb_hit)    dec_vec[wb_waddr_i]     = 1'b1;
    underflow = wb_hit && (cnt[wb_waddr_i] == '0) && !inc_vec[wb_waddr_i];
  end

  // Allocation is accepted only while the target counter has headroom
  always_comb begin
    regs_alloc_ready_o = (id_reg_waddr_i == '0) || (cnt[id_reg_waddr_i] != CNT_MAX);
  end

  // Register storage; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_waddr_i] <= wb_wdata_i;
    end
  end

  // Pending-writer counters: simultaneous alloc and retire on one register cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Sticky error on retiring a register that has no outstanding writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sb_err <= 1'b0;
    else if (underflow) sb_err <= 1'b1;
  end

  assign regs_sb_err_o = sb_err;

`ifdef REGS_WB_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Read ports with write-first forwarding; forwarding is suppressed in reset
  // so the outputs hold their reset values regardless of WB activity
  always_comb begin
    fwd1 = rst_n && wb_hit && (wb_waddr_i == id_reg1_raddr_i);
    fwd2 = rst_n && wb_hit && (wb_waddr_i == id_reg2_raddr_i);
    regs_reg1_rdata_o = '0;
    regs_reg2_rdata_o = '0;
    if (id_reg1_raddr_i != '0) regs_reg1_rdata_o = fwd1 ? wb_wdata_i : rf[id_reg1_raddr_i];
    if (id_reg2_raddr_i != '0) regs_reg2_rdata_o = fwd2 ? wb_wdata_i : rf[id_reg2_raddr_i];
    // A retiring last writer (count 1) reads as not busy; count 0 stays not busy
    regs_reg1_busy_o = (id_reg1_raddr_i != '0) && (cnt[id_reg1_raddr_i] != '0) &&
                       !(fwd1 && (cnt[id_reg1_raddr_i] == CNT_ONE));
    regs_reg2_busy_o = (id_reg2_raddr_i != '0) && (cnt[id_reg2_raddr_i] != '0) &&
                       !(fwd2 && (cnt[id_reg2_raddr_i] == CNT_ONE));
  end
`else
  // Read ports observe pre-edge state only
  always_comb begin
    regs_reg1_rdata_o = '0;
    regs_reg2_rdata_o = '0;
    if (id_reg1_raddr_i != '0) regs_reg1_rdata_o = rf[id_reg1_raddr_i];
    if (id_reg2_raddr_i != '0) regs_reg2_rdata_o = rf[id_reg2_raddr_i];
    regs_reg1_busy_o = (id_reg1_raddr_i != '0) && (cnt[id_reg1_raddr_i] != '0);
    regs_reg2_busy_o = (id_reg2_raddr_i != '0) && (cnt[id_reg2_raddr_i] != '0);
  end
`endif

endmodule

// File: tb/tb_regs.sv
// tb_regs: self-checking bench for regs. A behavioural model (arrays of
// register values and pending counts) predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_regs;

  localparam int XLEN = 32;
  localparam int MAXP = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      rs1 = '0, rs2 = '0;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            busy1, busy2;
  logic            alloc = 1'b0;
  logic [4:0]      alloc_addr = '0;
  logic            alloc_ready;
  logic            we = 1'b0;
  logic [4:0]      waddr = '0;
  logic [XLEN-1:0] wdata = '0;
  logic            sb_err;

  int checks = 0;
  int errors = 0;

  int unsigned m_rf  [32];
  int          m_cnt [32];
  bit          m_err;

  regs #(.XLEN(XLEN), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg1_raddr_i(rs1), .id_reg2_raddr_i(rs2),
    .regs_reg1_rdata_o(rdata1), .regs_reg2_rdata_o(rdata2),
    .regs_reg1_busy_o(busy1), .regs_reg2_busy_o(busy2),
    .id_alloc_i(alloc), .id_reg_waddr_i(alloc_addr),
    .regs_alloc_ready_o(alloc_ready),
    .wb_we_i(we), .wb_waddr_i(waddr), .wb_wdata_i(wdata),
    .regs_sb_err_o(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_cnt[i] = 0; end
    m_err = 0;
  endtask

  function automatic bit bypass_on();
`ifdef REGS_WB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!rst_n || a == 0) return 32'h0;
    if (bypass_on() && we && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    int n;
    if (a == 0) return 1'b0;
    n = m_cnt[a];
    if (bypass_on() && rst_n && we && waddr == a && n > 0) n = n - 1;
    return n != 0;
  endfunction

  function automatic logic exp_ready();
    return alloc_addr == 0 || m_cnt[alloc_addr] != MAXP;
  endfunction

  task automatic model_check();
    chk("rdata1", rdata1, exp_data(rs1));
    chk("rdata2", rdata2, exp_data(rs2));
    chk("busy1", 32'(busy1), 32'(exp_busy(rs1)));
    chk("busy2", 32'(busy2), 32'(exp_busy(rs2)));
    chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready()));
    chk("sb_err", 32'(sb_err), 32'(m_err));
  endtask

  task automatic model_update();
    bit inc, dec;
    inc = alloc && alloc_addr != 0 && m_cnt[alloc_addr] != MAXP;
    dec = we && waddr != 0;
    if (dec) m_rf[waddr] = wdata;
    if (!(inc && dec && alloc_addr == waddr)) begin
      if (inc) m_cnt[alloc_addr]++;
      if (dec) begin
        if (m_cnt[waddr] == 0) m_err = 1;
        else m_cnt[waddr]--;
      end
    end
  endtask

  // Check at the falling edge, then advance the model across the rising edge
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  task automatic idle();
    alloc = 0; we = 0;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    // Reset state on all addresses
    #2;
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a); rs2 = 5'(31 - a);
      #1;
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_rdata2", rdata2, 32'h0);
      chk("rst_busy", 32'({busy1, busy2}), 32'h0);
      chk("rst_ready", 32'(alloc_ready), 32'h1);
      chk("rst_err", 32'(sb_err), 32'h0);
    end
    @(negedge clk); rst_n = 1;
    tick();

    // Plain write and read-back; x0 ignores writes
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; cycle();
    idle(); rs1 = 5; rs2 = 5; sample();
    chk("x5_rd1", rdata1, 32'hDEADBEEF); chk("x5_rd2", rdata2, 32'hDEADBEEF); tick();
    we = 1; waddr = 0; wdata = 32'h1234; cycle();
    idle(); rs1 = 0; rs2 = 0; sample(); chk("x0_rd", rdata1, 32'h0); tick();

    // Allocate x7, then retire it while reading
    alloc = 1; alloc_addr = 7; cycle();
    idle(); rs1 = 7; sample(); chk("x7_busy", 32'(busy1), 32'h1); tick();
    we = 1; waddr = 7; wdata = 32'h55; rs1 = 7; sample();
`ifdef REGS_WB_BYPASS_EN
    chk("x7_same_data", rdata1, 32'h55); chk("x7_same_busy", 32'(busy1), 32'h0);
`else
    chk("x7_same_data", rdata1, 32'h0); chk("x7_same_busy", 32'(busy1), 32'h1);
`endif
    tick();
    idle(); sample(); chk("x7_next_data", rdata1, 32'h55); chk("x7_next_busy", 32'(busy1), 32'h0); tick();

    // Saturate x3, drop a fourth alloc, retire three times
    alloc_addr = 3; rs1 = 3;
    for (int k = 0; k < 3; k++) begin alloc = 1; cycle(); end
    alloc = 0; sample(); chk("x3_ready_sat", 32'(alloc_ready), 32'h0); tick();
    alloc = 1; cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); we = 1; waddr = 3; wdata = 32'(k); cycle();
      idle(); sample(); chk("x3_busy_drain", 32'(busy1), (k == 2) ? 32'h0 : 32'h1); tick();
    end

    // Alloc and retire x9 together with count 1; alloc to x0
    alloc = 1; alloc_addr = 9; cycle();
    alloc = 1; alloc_addr = 9; we = 1; waddr = 9; wdata = 32'h99; cycle();
    idle(); rs1 = 9; sample(); chk("x9_busy_hold", 32'(busy1), 32'h1); tick();
    alloc = 1; alloc_addr = 0; rs2 = 0; sample(); chk("x0_ready", 32'(alloc_ready), 32'h1); tick();
    idle(); sample(); chk("x9_busy_after_x0", 32'(busy1), 32'h1); chk("x0_busy", 32'(busy2), 32'h0); tick();
    we = 1; waddr = 9; cycle();

    // Underflow on x12 is sticky
    we = 1; waddr = 12; wdata = 32'h12; cycle();
    idle(); sample(); chk("sb_err_set", 32'(sb_err), 32'h1); tick();
    alloc = 1; alloc_addr = 4; cycle();
    we = 1; waddr = 4; alloc = 0; cycle();
    idle(); sample(); chk("sb_err_sticky", 32'(sb_err), 32'h1); tick();

    // Randomized traffic with periodic asynchronous resets mid-operation
    for (int n = 0; n < 3000; n++) begin
      rs1 = pick_addr(); rs2 = pick_addr();
      alloc = 1'($urandom_range(0, 1)); alloc_addr = pick_addr();
      we = ($urandom_range(0, 2) != 0); wdata = $urandom;
      waddr = pick_addr();
      for (int t = 0; t < 8 && $urandom_range(0, 4) != 0; t++) begin
        if (m_cnt[waddr] > 0) break;
        waddr = pick_addr();
      end
      cycle();
      if (n % 700 == 699) begin
        we = 1; waddr = rs1; alloc = 1;
        rst_n = 0; #1;
        chk("midrst_rdata1", rdata1, 32'h0);
        chk("midrst_rdata2", rdata2, 32'h0);
        chk("midrst_busy", 32'({busy1, busy2}), 32'h0);
        chk("midrst_ready", 32'(alloc_ready), 32'h1);
        chk("midrst_err", 32'(sb_err), 32'h0);
        model_reset();
        sample();
        rst_n = 1;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
